// File: rtl/cc_chan_pkg.sv
// Shared types and header field positions for the cc channel receive path.
// The FIFO entry layout follows CC_DATA_W; cc_chan_rx's DATA_W must match it.
package cc_chan_pkg;

   localparam int CC_DATA_W    = 7;
   localparam int CC_LEN_W     = 5;

   localparam int HDR_DEST_BIT = 0;
   localparam int HDR_LEN_LSB  = 1;
   localparam int HDR_PAR_BIT  = CC_DATA_W - 1;

   typedef enum logic {
      IDLE    = 1'b0,
      PAYLOAD = 1'b1
   } state_t;

   typedef struct packed {
      logic                 dest;
      logic [CC_DATA_W-1:0] data;
   } fifo_entry_t;

   // Header carries odd parity, so a good header has an odd number of ones overall.
   function automatic logic hdr_parity_ok(input logic [CC_DATA_W-1:0] hdr);
      return ^hdr;
   endfunction

endpackage

// File: rtl/cc_chan_fifo.sv
// Small synchronous FIFO with registered storage, occupancy counter and full/empty flags.
// Head entry is read straight from the storage registers, so a push is visible one cycle later.
module cc_chan_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cc_chan_rx.sv
// Receive end of the cc channel: header/payload framing, FIFO buffering and local/pass routing.
// Optional header parity check is enabled by defining CC_CHAN_RX_PARITY_EN.
module cc_chan_rx
   import cc_chan_pkg::*;
#(
   parameter int DATA_W = CC_DATA_W,
   parameter int DEPTH  = 4,
   parameter int LEN_W  = CC_LEN_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ch_valid,
   input  logic [DATA_W-1:0] ch_data,
   output logic              ch_ready,
   output logic              loc_valid,
   output logic [DATA_W-1:0] loc_data,
   input  logic              loc_ready,
   output logic              pass_valid,
   output logic [DATA_W-1:0] pass_data,
   input  logic              pass_ready,
   output logic              busy,
   output logic              err
);

   state_t           state;
   state_t           state_next;
   logic [LEN_W-1:0] rem;
   logic [LEN_W-1:0] hdr_len;
   logic             dest_q;
   logic             frame_drop;
   logic             accept;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   fifo_entry_t      push_entry;
   fifo_entry_t      head;

   assign ch_ready = !full && !reset;
   assign accept   = ch_valid && ch_ready;
   assign hdr_len  = ch_data[HDR_LEN_LSB +: LEN_W];

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Null frames (L=0) are fully handled in IDLE and never enter PAYLOAD.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept && (hdr_len != '0)) begin
               state_next = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (accept && (rem == LEN_W'(1))) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy            = (state == PAYLOAD);
      push            = accept && (state == PAYLOAD) && !frame_drop;
      push_entry.dest = dest_q;
      push_entry.data = ch_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rem    <= '0;
         dest_q <= 1'b0;
      end else if (accept) begin
         if (state == IDLE) begin
            rem    <= hdr_len;
            dest_q <= ch_data[HDR_DEST_BIT];
         end else begin
            rem    <= rem - LEN_W'(1);
         end
      end
   end

`ifdef CC_CHAN_RX_PARITY_EN
   logic drop_q;
   logic err_q;
   logic hdr_bad;

   assign hdr_bad = !hdr_parity_ok(ch_data);

   // A bad header still frames its payload so the stream stays aligned; the words are just not stored.
   always_ff @(posedge clock) begin
      if (reset) begin
         drop_q <= 1'b0;
         err_q  <= 1'b0;
      end else if (accept && (state == IDLE)) begin
         drop_q <= hdr_bad;
         if (hdr_bad) begin
            err_q <= 1'b1;
         end
      end
   end

   assign frame_drop = drop_q;
   assign err        = err_q;
`else
   assign frame_drop = 1'b0;
   assign err        = 1'b0;
`endif

   cc_chan_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head_data (head),
      .full      (full),
      .empty     (empty)
   );

   // Head-of-line routing: the head's dest picks the port, so a blocked pass word stalls local traffic too.
   always_comb begin
      loc_valid  = !empty && head.dest;
      pass_valid = !empty && !head.dest;
      loc_data   = loc_valid  ? head.data : '0;
      pass_data  = pass_valid ? head.data : '0;
      pop        = (loc_valid && loc_ready) || (pass_valid && pass_ready);
   end

endmodule

// File: tb/tb_cc_chan_rx.sv
// Self-checking bench for cc_chan_rx: a framing model fills per-port expected queues,
// and a negedge monitor pops and compares every word the DUT hands out.
`timescale 1ns/1ps
module tb_cc_chan_rx;

   localparam int DATA_W = 7;
   localparam int DEPTH  = 4;
   localparam int LEN_W  = 5;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              ch_valid = 1'b0;
   logic [DATA_W-1:0] ch_data = '0;
   logic              ch_ready;
   logic              loc_valid;
   logic [DATA_W-1:0] loc_data;
   logic              loc_ready = 1'b0;
   logic              pass_valid;
   logic [DATA_W-1:0] pass_data;
   logic              pass_ready = 1'b0;
   logic              busy;
   logic              err;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] loc_q[$];
   logic [DATA_W-1:0] pass_q[$];
   logic [DATA_W-1:0] mon_exp;

   bit m_in_pay = 1'b0;
   bit m_dest   = 1'b0;
   bit m_drop   = 1'b0;
   int m_rem    = 0;

   cc_chan_rx #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .LEN_W  (LEN_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .ch_valid   (ch_valid),
      .ch_data    (ch_data),
      .ch_ready   (ch_ready),
      .loc_valid  (loc_valid),
      .loc_data   (loc_data),
      .loc_ready  (loc_ready),
      .pass_valid (pass_valid),
      .pass_data  (pass_data),
      .pass_ready (pass_ready),
      .busy       (busy),
      .err        (err)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Odd parity in the top bit so headers are valid whether or not the parity check is built in.
   function automatic logic [DATA_W-1:0] make_hdr(input logic dest, input logic [LEN_W-1:0] len);
      logic [DATA_W-1:0] h;
      h = {1'b0, len, dest};
      h[DATA_W-1] = ~(^h[DATA_W-2:0]);
      return h;
   endfunction

   task automatic model_accept(input logic [DATA_W-1:0] w);
      if (!m_in_pay) begin
         m_dest = w[0];
         m_rem  = int'(w[LEN_W:1]);
`ifdef CC_CHAN_RX_PARITY_EN
         m_drop = ((^w) == 1'b0);
`else
         m_drop = 1'b0;
`endif
         m_in_pay = (m_rem != 0);
      end else begin
         if (!m_drop) begin
            if (m_dest) loc_q.push_back(w);
            else        pass_q.push_back(w);
         end
         m_rem--;
         if (m_rem == 0) m_in_pay = 1'b0;
      end
   endtask

   task automatic model_reset();
      m_in_pay = 1'b0;
      m_dest   = 1'b0;
      m_drop   = 1'b0;
      m_rem    = 0;
      loc_q.delete();
      pass_q.delete();
   endtask

   task automatic send_word(input logic [DATA_W-1:0] w);
      int waited;
      waited   = 0;
      ch_valid = 1'b1;
      ch_data  = w;
      @(negedge clock);
      while (ch_ready !== 1'b1 && waited < 64) begin
         @(negedge clock);
         waited++;
      end
      if (ch_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("[TB] FAIL send_timeout: ch_ready=%b required 1 for word 0x%h", ch_ready, w);
         ch_valid = 1'b0;
      end else begin
         model_accept(w);
      end
      @(posedge clock);
      #1;
      ch_valid = 1'b0;
      ch_data  = '0;
   endtask

   // Every handshake on either output port is checked against the model's expected queue.
   always @(negedge clock) begin
      if (!reset) begin
         if (loc_valid === 1'b1 && pass_valid === 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL both_valid: loc_valid=%b pass_valid=%b required one-hot", loc_valid, pass_valid);
         end
         if (loc_valid === 1'b1 && loc_ready === 1'b1) begin
            checks++;
            if (loc_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL loc_extra: got 0x%h required no word", loc_data);
            end else begin
               mon_exp = loc_q.pop_front();
               if (loc_data !== mon_exp) begin
                  errors++;
                  $display("[TB] FAIL loc_data: got 0x%h required 0x%h", loc_data, mon_exp);
               end
            end
         end
         if (pass_valid === 1'b1 && pass_ready === 1'b1) begin
            checks++;
            if (pass_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL pass_extra: got 0x%h required no word", pass_data);
            end else begin
               mon_exp = pass_q.pop_front();
               if (pass_data !== mon_exp) begin
                  errors++;
                  $display("[TB] FAIL pass_data: got 0x%h required 0x%h", pass_data, mon_exp);
               end
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checks++;
      if (ch_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ch_ready: got %b required 0", ch_ready);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({ch_ready, loc_valid, pass_valid, busy, err} !== 5'b10000) begin
         errors++;
         $display("[TB] FAIL reset_idle: ready/lv/pv/busy/err=%b required 10000",
                  {ch_ready, loc_valid, pass_valid, busy, err});
      end
      checks++;
      if (loc_data !== '0 || pass_data !== '0) begin
         errors++;
         $display("[TB] FAIL reset_data: loc=0x%h pass=0x%h required 0", loc_data, pass_data);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_local();
      loc_ready  = 1'b1;
      pass_ready = 1'b0;
      send_word(7'b0000111);
      send_word(7'h11);
      @(negedge clock);
      checks++;
      if (loc_valid !== 1'b1 || loc_data !== 7'h11 || pass_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL local_latency: lv=%b data=0x%h pv=%b required 1/0x11/0",
                  loc_valid, loc_data, pass_valid);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL local_busy_mid: got %b required 1", busy);
      end
      @(posedge clock);
      #1;
      send_word(7'h22);
      send_word(7'h33);
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL local_busy_end: got %b required 0", busy);
      end
      repeat (4) @(posedge clock);
      #1;
      checks++;
      if (loc_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL local_drain: %0d words left required 0", loc_q.size());
      end
   endtask

   task automatic test_backpressure();
      loc_ready  = 1'b0;
      pass_ready = 1'b0;
      send_word(7'b0001000);
      for (int i = 0; i < 4; i++) send_word(7'h41 + 7'(i));
      @(negedge clock);
      checks++;
      if (ch_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_full_ready: got %b required 0", ch_ready);
      end
      checks++;
      if (pass_valid !== 1'b1 || pass_data !== 7'h41 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_head: pv=%b data=0x%h busy=%b required 1/0x41/0", pass_valid, pass_data, busy);
      end
      @(posedge clock);
      #1;
      pass_ready = 1'b1;
      @(negedge clock);
      checks++;
      if (ch_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_ready_before_pop: got %b required 0", ch_ready);
      end
      @(negedge clock);
      checks++;
      if (ch_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_ready_after_pop: got %b required 1", ch_ready);
      end
      repeat (5) @(posedge clock);
      #1;
      checks++;
      if (pass_q.size() != 0 || pass_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_drain: left=%0d pv=%b required 0/0", pass_q.size(), pass_valid);
      end
   endtask

   task automatic test_back_to_back();
      loc_ready  = 1'b1;
      pass_ready = 1'b1;
      send_word(make_hdr(1'b0, 5'd0));
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL null_busy: got %b required 0", busy);
      end
      @(posedge clock);
      #1;
      send_word(make_hdr(1'b1, 5'd1));
      send_word(7'h05);
      send_word(make_hdr(1'b0, 5'd1));
      send_word(7'h0A);
      repeat (5) @(posedge clock);
      #1;
      checks++;
      if (loc_q.size() != 0 || pass_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL b2b_drain: loc_left=%0d pass_left=%0d required 0/0", loc_q.size(), pass_q.size());
      end
   endtask

   task automatic test_order();
      loc_ready  = 1'b1;
      pass_ready = 1'b0;
      send_word(make_hdr(1'b0, 5'd1));
      send_word(7'h15);
      send_word(make_hdr(1'b1, 5'd1));
      send_word(7'h16);
      @(negedge clock);
      checks++;
      if (loc_valid !== 1'b0 || pass_valid !== 1'b1 || pass_data !== 7'h15) begin
         errors++;
         $display("[TB] FAIL order_block: lv=%b pv=%b pdata=0x%h required 0/1/0x15", loc_valid, pass_valid, pass_data);
      end
      @(posedge clock);
      #1;
      pass_ready = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      checks++;
      if (loc_q.size() != 0 || pass_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL order_drain: loc_left=%0d pass_left=%0d required 0/0", loc_q.size(), pass_q.size());
      end
   endtask

   task automatic test_reset_mid();
      loc_ready  = 1'b0;
      pass_ready = 1'b0;
      send_word(7'b0000111);
      send_word(7'h21);
      reset = 1'b1;
      model_reset();
      @(negedge clock);
      checks++;
      if (ch_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_ready_low: got %b required 0", ch_ready);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({ch_ready, loc_valid, pass_valid, busy} !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL midreset_state: ready/lv/pv/busy=%b required 1000",
                  {ch_ready, loc_valid, pass_valid, busy});
      end
      @(posedge clock);
      #1;
      loc_ready = 1'b1;
      send_word(make_hdr(1'b1, 5'd1));
      send_word(7'h2A);
      repeat (4) @(posedge clock);
      #1;
      checks++;
      if (loc_q.size() != 0 || pass_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL midreset_drain: loc_left=%0d pass_left=%0d required 0/0", loc_q.size(), pass_q.size());
      end
   endtask

`ifdef CC_CHAN_RX_PARITY_EN
   task automatic test_parity();
      loc_ready  = 1'b1;
      pass_ready = 1'b1;
      send_word(make_hdr(1'b1, 5'd2) ^ 7'h40);
      @(negedge clock);
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL parity_err_set: got %b required 1", err);
      end
      @(posedge clock);
      #1;
      send_word(7'h31);
      send_word(7'h32);
      @(negedge clock);
      checks++;
      if (loc_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL parity_drop: lv=%b busy=%b required 0/0", loc_valid, busy);
      end
      @(posedge clock);
      #1;
      send_word(make_hdr(1'b1, 5'd1));
      send_word(7'h33);
      repeat (4) @(posedge clock);
      #1;
      checks++;
      if (err !== 1'b1 || loc_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL parity_after: err=%b loc_left=%0d required 1/0", err, loc_q.size());
      end
   endtask
`endif

   initial begin
      test_reset();
      test_local();
      test_backpressure();
      test_back_to_back();
      test_order();
      test_reset_mid();
`ifdef CC_CHAN_RX_PARITY_EN
      test_parity();
`else
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_tied_low: got %b required 0", err);
      end
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
